// File: rtl/scc_data_mem.sv
// Word-organised data memory behind the SCC core data port, with a wait-state
// sequencer and sticky fault capture for misaligned, out-of-range and conflicting accesses.
module scc_data_mem #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_s,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic        data_read,
    input  logic        data_write,
    output logic [31:0] data_rdata,
    output logic        data_ready,
    output logic        busy,
    output logic        bus_err,
    output logic [31:0] err_addr,
    input  logic        err_clr
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        write_q;
    logic        fault_q;
    logic [32:0] off;
    logic        req_fault;
    logic [AW-1:0] idx;
    logic        mem_we;
    logic [31:0] mem [DEPTH];

    // 33-bit offset: bit 32 is the borrow, i.e. the address lies below ADDR_BASE.
    // ADDR_BASE is word aligned, so the offset's low bits equal the address's.
    always_comb begin
        off       = {1'b0, data_addr} - {1'b0, ADDR_BASE};
        req_fault = (data_read && data_write)
                 || (off[1:0] != 2'b00)
                 || off[32]
                 || ({2'b00, off[31:2]} >= DEPTH);
    end

    always_comb idx = AW'((addr_q - ADDR_BASE) >> 2);
    always_comb mem_we = (state == ACCESS) && write_q && !fault_q;

    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= wdata_q;
    end

    always_ff @(posedge clk or negedge reset_s) begin
        if (!reset_s) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            fault_q    <= 1'b0;
            data_rdata <= '0;
            data_ready <= 1'b0;
            busy       <= 1'b0;
            bus_err    <= 1'b0;
            err_addr   <= '0;
        end else begin
            data_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_read || data_write) begin
                        addr_q  <= data_addr;
                        wdata_q <= data_wdata;
                        write_q <= data_write;
                        fault_q <= req_fault;
                        busy    <= 1'b1;
                        cnt     <= 4'(WAIT_STATES);
                        state   <= (WAIT_STATES == 0) ? ACCESS : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1) state <= ACCESS;
                end
                ACCESS: begin
                    if (fault_q)       data_rdata <= '0;
                    else if (!write_q) data_rdata <= mem[idx];
                    data_ready <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // A fault completing on the same edge as err_clr takes precedence.
            if ((state == ACCESS) && fault_q) begin
                bus_err <= 1'b1;
                if (!bus_err || err_clr) err_addr <= addr_q;
            end else if (err_clr) begin
                bus_err  <= 1'b0;
                err_addr <= '0;
            end
        end
    end
endmodule
